// File: rtl/vm2413.sv
// Shared types and lookup tables for the FM phase path.
package vm2413;

  typedef logic [4:0]  SLOT_TYPE;
  typedef logic [17:0] PHASE_TYPE;
  typedef logic [8:0]  PGOUT_TYPE;

  localparam int unsigned NUM_SLOTS = 18;
  localparam int unsigned LFSR_W    = 23;

  function automatic logic [4:0] mltab(input logic [3:0] ml);
    logic [4:0] v;
    case (ml)
      4'd0:    v = 5'd1;
      4'd1:    v = 5'd2;
      4'd2:    v = 5'd4;
      4'd3:    v = 5'd6;
      4'd4:    v = 5'd8;
      4'd5:    v = 5'd10;
      4'd6:    v = 5'd12;
      4'd7:    v = 5'd14;
      4'd8:    v = 5'd16;
      4'd9:    v = 5'd18;
      4'd10:   v = 5'd20;
      4'd11:   v = 5'd20;
      4'd12:   v = 5'd24;
      4'd13:   v = 5'd24;
      4'd14:   v = 5'd30;
      4'd15:   v = 5'd30;
      default: v = 5'd1;
    endcase
    return v;
  endfunction

  // Triangle vibrato shape, one step per LFO count.
  function automatic logic signed [2:0] vib_tab(input logic [2:0] idx);
    logic signed [2:0] v;
    case (idx)
      3'd0:    v = 3'sd0;
      3'd1:    v = 3'sd1;
      3'd2:    v = 3'sd2;
      3'd3:    v = 3'sd1;
      3'd4:    v = 3'sd0;
      3'd5:    v = -3'sd1;
      3'd6:    v = -3'sd2;
      3'd7:    v = -3'sd1;
      default: v = 3'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/phase_generator_if.sv
// Slot sequencing, channel parameters and phase memory port of the phase generator.
interface phase_generator_if;
  import vm2413::*;

  SLOT_TYPE  slot;
  logic [1:0] stage;
  logic [8:0] fnum;
  logic [2:0] blk;
  logic [3:0] ml;
  logic       pm;
  logic       key;
  PHASE_TYPE  memout;
  logic       memwr;
  PHASE_TYPE  memin;
  PGOUT_TYPE  pg_out;
  logic       noise;

  modport master (
    output slot, stage, fnum, blk, ml, pm, key, memout,
    input  memwr, memin, pg_out, noise
  );

  modport slave (
    input  slot, stage, fnum, blk, ml, pm, key, memout,
    output memwr, memin, pg_out, noise
  );
endinterface

// File: rtl/phase_incr.sv
// Combinational phase increment from F-number, block, multiplier and vibrato.
module phase_incr
  import vm2413::*;
(
  input  logic [8:0] i_fnum,
  input  logic [2:0] i_blk,
  input  logic [3:0] i_ml,
  input  logic       i_pm,
  input  logic [2:0] i_pm_cnt,
  output PHASE_TYPE  o_inc
);

  logic signed [6:0] w_vib;
  logic signed [6:0] w_fsel;
  logic signed [6:0] w_off;
  logic [10:0]       w_fnum_eff;
  logic [22:0]       w_mult;

  assign w_vib  = 7'(vib_tab(i_pm_cnt));
  assign w_fsel = $signed({4'b0000, i_fnum[8:6]});

  // Vibrato offset, spans -14..14.
  always_comb begin
    w_off = 7'sd0;
    if (i_pm) begin
      w_off = w_vib * w_fsel;
    end else begin
      w_off = 7'sd0;
    end
  end

  // Offset never exceeds 2*fnum, so the 11-bit modular sum is the true value.
  assign w_fnum_eff = {1'b0, i_fnum, 1'b0} + {{4{w_off[6]}}, w_off};
  assign w_mult     = {12'd0, w_fnum_eff} * {18'd0, mltab(i_ml)};
  assign o_inc      = PHASE_TYPE'((w_mult << i_blk) >> 2'd2);

endmodule

// File: rtl/phase_generator.sv
// Per-slot phase accumulator over a 4-clock slot, plus vibrato LFO and noise LFSR.
module phase_generator
  import vm2413::*;
(
  input  logic               clk,
  input  logic               reset_n,
  phase_generator_if.slave   pg_if
);

  logic [NUM_SLOTS-1:0] r_key_prev;
  logic                 r_memwr;
  PHASE_TYPE            r_memin;
  PGOUT_TYPE            r_pg_out;
  logic                 r_noise;
  logic [9:0]           r_prescaler;
  logic [2:0]           r_pm_cnt;
  logic [LFSR_W-1:0]    r_lfsr;

  PHASE_TYPE            w_inc;
  PHASE_TYPE            w_next;
  logic                 w_slot_ok;
  logic                 w_prev_key;
  logic                 w_keyon;
  logic                 w_sample_end;

  phase_incr u_incr (
    .i_fnum   (pg_if.fnum),
    .i_blk    (pg_if.blk),
    .i_ml     (pg_if.ml),
    .i_pm     (pg_if.pm),
    .i_pm_cnt (r_pm_cnt),
    .o_inc    (w_inc)
  );

  assign w_slot_ok    = (pg_if.slot < 5'd18);
  assign w_prev_key   = w_slot_ok ? r_key_prev[pg_if.slot] : 1'b1;
  assign w_keyon      = pg_if.key & ~w_prev_key;
  assign w_next       = pg_if.memout + w_inc;
  assign w_sample_end = (pg_if.stage == 2'd3) && (pg_if.slot == 5'd17);

  // Slot pipeline: memout arrives in stage 1, write in stage 2, publish in stage 3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_memwr    <= 1'b0;
      r_memin    <= 18'd0;
      r_pg_out   <= 9'd0;
      r_key_prev <= 18'd0;
    end else begin
      case (pg_if.stage)
        2'd1: begin
          r_memwr <= 1'b1;
          r_memin <= w_keyon ? 18'd0 : w_next;
        end
        2'd2: begin
          r_memwr <= 1'b0;
          if (w_slot_ok) begin
            r_key_prev[pg_if.slot] <= pg_if.key;
          end
        end
        2'd3: begin
          r_memwr  <= 1'b0;
          r_pg_out <= r_memin[17:9];
        end
        default: r_memwr <= 1'b0;
      endcase
    end
  end

  // Once-per-sample LFO prescaler/counter and x^23+x^9+1 noise LFSR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescaler <= 10'd0;
      r_pm_cnt    <= 3'd0;
      r_lfsr      <= 23'h000001;
      r_noise     <= 1'b0;
    end else if (w_sample_end) begin
      r_prescaler <= r_prescaler + 10'd1;
      if (r_prescaler == 10'h3FF) begin
        r_pm_cnt <= r_pm_cnt + 3'd1;
      end
      r_lfsr  <= {r_lfsr[21:0], r_lfsr[22] ^ r_lfsr[8]};
      r_noise <= r_lfsr[0];
    end
  end

  assign pg_if.memwr  = r_memwr;
  assign pg_if.memin  = r_memin;
  assign pg_if.pg_out = r_pg_out;
  assign pg_if.noise  = r_noise;

endmodule

// File: tb/tb_phase_generator.sv
// Scoreboarded random/directed bench for phase_generator with a behavioural phase model.
module tb_phase_generator;
  import vm2413::*;

  logic clk;
  logic reset_n;
  phase_generator_if pif ();

  phase_generator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pg_if   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [17:0] val;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [17:0] mem     [18];
  logic [8:0]  fnum_a  [18];
  logic [2:0]  blk_a   [18];
  logic [3:0]  ml_a    [18];
  logic        pm_a    [18];
  logic        key_a   [18];
  bit          kp_m    [18];
  logic [8:0]  pg_seen [18];
  logic [8:0]  pg_exp = 9'd0;
  int          pg_slot = 0;
  int          samples = 0;

  // Phase step straight from the arithmetic rules, in plain integers.
  function automatic int ref_inc(int f, int b, int m, int p, int pc);
    int mt [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};
    int vt [8]  = '{0, 1, 2, 1, 0, -1, -2, -1};
    int off;
    off = (p != 0) ? vt[pc] * (f / 64) : 0;
    return (((2 * f + off) * mt[m]) << b) >> 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int s, input int f, input int b, input int m, input int p, input int k);
    fnum_a[s] = 9'(f);
    blk_a[s]  = 3'(b);
    ml_a[s]   = 4'(m);
    pm_a[s]   = 1'(p);
    key_a[s]  = 1'(k);
  endtask

  task automatic run_slot(input int s, input bit rst_mid);
    int   pc;
    exp_t e;
    for (int st = 0; st < 4; st++) begin
      @(posedge clk);
      #1;
      pif.slot   = 5'(s);
      pif.stage  = 2'(st);
      pif.fnum   = fnum_a[s];
      pif.blk    = blk_a[s];
      pif.ml     = ml_a[s];
      pif.pm     = pm_a[s];
      pif.key    = key_a[s];
      pif.memout = (st == 0) ? 18'd0 : mem[s];
      if (st == 1 && reset_n) begin
        pc    = (samples / 1024) % 8;
        e.slot = s;
        if (key_a[s] && !kp_m[s]) begin
          e.val = 18'd0;
        end else begin
          e.val = 18'((int'(mem[s]) + ref_inc(int'(fnum_a[s]), int'(blk_a[s]), int'(ml_a[s]),
                                                int'(pm_a[s]), pc)) % 262144);
        end
        exp_q.push_back(e);
      end
      if (st == 2) begin
        if (rst_mid) begin
          #2;
          reset_n = 1'b0;
          exp_q.delete();
          pg_exp  = 9'd0;
          samples = 0;
          for (int i = 0; i < 18; i++) kp_m[i] = 1'b0;
          #1;
          check("rst_memwr", 32'(pif.memwr), 32'd0);
          check("rst_memin", 32'(pif.memin), 32'd0);
          check("rst_pg_out", 32'(pif.pg_out), 32'd0);
          check("rst_noise", 32'(pif.noise), 32'd0);
          #3;
          reset_n = 1'b1;
        end
        kp_m[s] = key_a[s];
        if (pif.memwr) mem[s] = pif.memin;
      end
      if (st == 3 && s == 17) samples++;
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    pif.slot   = 5'd0;
    pif.stage  = 2'd0;
    pif.memout = 18'd0;
  endtask

  task automatic run_sample();
    for (int s = 0; s < 18; s++) run_slot(s, 1'b0);
    idle();
  endtask

  task automatic random_phase(input int visits);
    int s;
    for (int v = 0; v < visits; v++) begin
      s = int'($urandom_range(17, 0));
      set_slot(s, int'($urandom_range(511, 0)), int'($urandom_range(7, 0)),
               int'($urandom_range(15, 0)), int'($urandom_range(1, 0)),
               ($urandom_range(3, 0) != 0) ? 1 : 0);
      if ($urandom_range(3, 0) == 0) mem[s] = 18'($urandom_range(262143, 0));
      run_slot(s, 1'b0);
    end
    idle();
  endtask

  // Monitor: pops the scoreboard on every write strobe and tracks pg_out.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (pif.stage == 2'd2 && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("memwr_pulse", 32'(pif.memwr), 32'd1);
          check("memin", 32'(pif.memin), 32'(mon_e.val));
          pg_exp  = mon_e.val[17:9];
          pg_slot = mon_e.slot;
        end else begin
          check("memwr_idle", 32'(pif.memwr), 32'd0);
        end
        if (pif.stage == 2'd0) begin
          check("pg_out", 32'(pif.pg_out), 32'(pg_exp));
          pg_seen[pg_slot] = pif.pg_out;
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    pif.slot   = 5'd0;
    pif.stage  = 2'd0;
    pif.fnum   = 9'd0;
    pif.blk    = 3'd0;
    pif.ml     = 4'd0;
    pif.pm     = 1'b0;
    pif.key    = 1'b0;
    pif.memout = 18'd0;
    for (int i = 0; i < 18; i++) begin
      mem[i]     = 18'd0;
      kp_m[i]    = 1'b0;
      pg_seen[i] = 9'd0;
      set_slot(i, 256, 0, 1, 0, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_memwr", 32'(pif.memwr), 32'd0);
    check("reset_memin", 32'(pif.memin), 32'd0);
    check("reset_pg_out", 32'(pif.pg_out), 32'd0);
    check("reset_noise", 32'(pif.noise), 32'd0);
    #1 reset_n = 1'b1;

    mem[3] = 18'h00155;
    run_sample();
    check("keyon_first", 32'(mem[3]), 32'd0);
    check("noise_first", 32'(pif.noise), 32'd1);

    mem[0] = 18'h00100;
    mem[1] = 18'h3FF80;
    set_slot(2, 511, 7, 15, 0, 1);
    key_a[5] = 1'b0;
    run_sample();
    check("basic_memin", 32'(mem[0]), 32'h00200);
    check("basic_pg", 32'(pg_seen[0]), 32'h001);
    check("wrap_memin", 32'(mem[1]), 32'h00080);
    check("extreme_memin", 32'(mem[2]), 32'h2F880);
    check("extreme_pg", 32'(pg_seen[2]), 32'h17C);
    check("key_off_advance", 32'(mem[5]), 32'h00100);

    key_a[5] = 1'b1;
    run_sample();
    check("keyon_rekey", 32'(mem[5]), 32'd0);
    check("held_key_slot6", 32'(mem[6]), 32'h00200);
    run_sample();
    check("keyon_once", 32'(mem[5]), 32'h00100);
    check("held_key_slot6b", 32'(mem[6]), 32'h00300);

    set_slot(17, 448, 0, 1, 1, 1);
    while (samples < 2048) run_slot(17, 1'b0);
    set_slot(16, 448, 0, 1, 1, 1);
    set_slot(15, 448, 0, 1, 0, 1);
    mem[16] = 18'd0;
    mem[15] = 18'd0;
    run_slot(16, 1'b0);
    run_slot(15, 1'b0);
    idle();
    check("vibrato_inc", 32'(mem[16]), 32'd455);
    check("no_vibrato_inc", 32'(mem[15]), 32'd448);

    random_phase(150);
    set_slot(17, 448, 0, 1, 1, 1);
    while (samples < 5120) run_slot(17, 1'b0);
    random_phase(150);

    for (int i = 0; i < 18; i++) key_a[i] = 1'b1;
    mem[4] = 18'h00123;
    run_slot(3, 1'b1);
    run_slot(4, 1'b0);
    run_slot(3, 1'b0);
    idle();
    check("keyon_after_reset", 32'(mem[4]), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
